tl_cntr_w_left_struct: RTL and testbench

TL_CNTR_W_LEFT_STRUCT -- requirements
Module: tl_cntr_w_left_struct

---
 rtl/tl_cntr_w_left_struct.sv | 119 +++++++++++
 tb/tb_tl_cntr_w_left_struct.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_cntr_w_left_struct.sv
// tl_cntr_w_left_struct: traffic-light controller for two streets, each with
// a protected left-turn phase. Moore FSM built structurally from a 3-bit
// state register, a next-state logic block and an output decoder.
//
// State encoding (binary): S0=000 A green, S1=001 A yellow, S2=010 A left,
// S3=011 A yellow, S4=100 B green, S5=101 B yellow, S6=110 B left,
// S7=111 B yellow.
// Light encoding: Green=2'b00, Yellow=2'b01, Left=2'b10, Red=2'b11.
//
// Optional macro TL_STATE_PORT_EN adds a 3-bit output port 'state' that
// exposes the current state register. FSM behaviour does not change.

// Three D flip-flops with synchronous active-low reset to S0.
module tl_state_reg (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] d,
  output logic [2:0] q
);

  // State update on the rising edge; reset is only seen at the edge.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment keeps every flop sampling the
    // pre-edge value, so simulation matches the synthesized registers.
    if (!reset_n) q <= 3'b000;
    else          q <= d;
  end

endmodule

// Next-state logic. Every even state (green or left phase) holds while its
// own sensor is asserted and otherwise advances; every odd state is a
// one-cycle yellow and always advances. S7 wraps to S0 through the 3-bit
// increment.
module tl_next_state (
  input  logic [2:0] s,
  input  logic       Ta,
  input  logic       Tal,
  input  logic       Tb,
  input  logic       Tbl,
  output logic [2:0] ns
);

  logic sensor;
  logic hold;

  // s[2] picks the street, s[1] picks through lanes vs left-turn lane, so
  // only the sensor belonging to the current phase can influence it.
  assign sensor = s[2] ? (s[1] ? Tbl : Tb) : (s[1] ? Tal : Ta);
  assign hold   = ~s[0] & sensor;
  assign ns     = hold ? s : (s + 3'd1);

endmodule

// Output decoder: state-only (Moore) light outputs.
//   A: S0 00, S1 01, S2 10, S3 01, S4..S7 11
//   B: S0..S3 11, S4 00, S5 01, S6 10, S7 01
// Exactly one street is ever away from Red because s[2] forces the other
// street to 11.
module tl_output_logic (
  input  logic [2:0] s,
  output logic [1:0] La,
  output logic [1:0] Lb
);

  assign La[1] =  s[2] | (s[1] & ~s[0]);
  assign La[0] =  s[2] |  s[0];
  assign Lb[1] = ~s[2] | (s[1] & ~s[0]);
  assign Lb[0] = ~s[2] |  s[0];

endmodule

// Top level: structural composition only, no behavioural code.
module tl_cntr_w_left_struct (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Ta,
  input  logic       Tal,
  input  logic       Tb,
  input  logic       Tbl,
  output logic [1:0] La,
`ifdef TL_STATE_PORT_EN
  output logic [1:0] Lb,
  output logic [2:0] state
`else
  output logic [1:0] Lb
`endif
);

  logic [2:0] state_q;
  logic [2:0] state_d;

  tl_state_reg u_state_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (state_d),
    .q       (state_q)
  );

  tl_next_state u_next_state (
    .s   (state_q),
    .Ta  (Ta),
    .Tal (Tal),
    .Tb  (Tb),
    .Tbl (Tbl),
    .ns  (state_d)
  );

  tl_output_logic u_output_logic (
    .s  (state_q),
    .La (La),
    .Lb (Lb)
  );

`ifdef TL_STATE_PORT_EN
  assign state = state_q;
`endif

endmodule

// File: tb/tb_tl_cntr_w_left_struct.sv
// Directed testbench for tl_cntr_w_left_struct. Inputs change 1 ns after the
// rising edge and outputs are sampled at that same point, away from the edge.
module tb_tl_cntr_w_left_struct;

  localparam logic [1:0] GRN = 2'b00;
  localparam logic [1:0] YEL = 2'b01;
  localparam logic [1:0] LFT = 2'b10;
  localparam logic [1:0] RED = 2'b11;

  logic       clk;
  logic       reset_n;
  logic       Ta, Tal, Tb, Tbl;
  logic [1:0] La, Lb;
`ifdef TL_STATE_PORT_EN
  logic [2:0] state;
`endif

  int total = 0;
  int bad   = 0;

  tl_cntr_w_left_struct dut (
    .clk     (clk),
    .reset_n (reset_n),
    .Ta      (Ta),
    .Tal     (Tal),
    .Tb      (Tb),
    .Tbl     (Tbl),
    .La      (La),
`ifdef TL_STATE_PORT_EN
    .Lb      (Lb),
    .state   (state)
`else
    .Lb      (Lb)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Put the DUT in S0 with all sensors low (no checking here).
  task automatic go_s0();
    {Ta, Tal, Tb, Tbl} = 4'b0000;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    {Ta, Tal, Tb, Tbl} = 4'b1111;
    step();
    total++;
    if (La !== GRN || Lb !== RED) begin
      bad++;
      $display("FAIL reset: La=%b Lb=%b expected La=%b Lb=%b", La, Lb, GRN, RED);
    end
`ifdef TL_STATE_PORT_EN
    total++;
    if (state !== 3'b000) begin
      bad++;
      $display("FAIL reset_state: state=%b expected 000", state);
    end
`endif
    reset_n = 1'b1;
    {Ta, Tal, Tb, Tbl} = 4'b0000;
  endtask

  task automatic test_hold();
    go_s0();
    Ta = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (La !== GRN || Lb !== RED) begin
        bad++;
        $display("FAIL hold[%0d]: La=%b Lb=%b expected La=%b Lb=%b", i, La, Lb, GRN, RED);
      end
    end
    Ta = 1'b0;
  endtask

  task automatic test_full_cycle();
    logic [1:0] exp_la [8];
    logic [1:0] exp_lb [8];
    exp_la = '{YEL, LFT, YEL, RED, RED, RED, RED, GRN};
    exp_lb = '{RED, RED, RED, GRN, YEL, LFT, YEL, RED};
    go_s0();
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if (La !== exp_la[i] || Lb !== exp_lb[i]) begin
        bad++;
        $display("FAIL full_cycle[%0d]: La=%b Lb=%b expected La=%b Lb=%b",
                 i, La, Lb, exp_la[i], exp_lb[i]);
      end
`ifdef TL_STATE_PORT_EN
      total++;
      if (state !== 3'((i + 1) % 8)) begin
        bad++;
        $display("FAIL full_cycle_state[%0d]: state=%b expected %0d", i, state, (i + 1) % 8);
      end
`endif
    end
  endtask

  // In S0 only Ta matters: the other three sensors high must not hold it.
  task automatic test_ignore_other_sensors();
    go_s0();
    {Ta, Tal, Tb, Tbl} = 4'b0111;
    step();
    total++;
    if (La !== YEL || Lb !== RED) begin
      bad++;
      $display("FAIL ignore_s0: La=%b Lb=%b expected La=%b Lb=%b", La, Lb, YEL, RED);
    end
    // S1 is unconditional even with every sensor high; lands in S2 (A left).
    {Ta, Tal, Tb, Tbl} = 4'b1111;
    step();
    total++;
    if (La !== LFT || Lb !== RED) begin
      bad++;
      $display("FAIL ignore_s1: La=%b Lb=%b expected La=%b Lb=%b", La, Lb, LFT, RED);
    end
    // S2 with Tal=0 but Ta/Tb/Tbl high must advance to S3.
    {Ta, Tal, Tb, Tbl} = 4'b1011;
    step();
    total++;
    if (La !== YEL || Lb !== RED) begin
      bad++;
      $display("FAIL ignore_s2: La=%b Lb=%b expected La=%b Lb=%b", La, Lb, YEL, RED);
    end
    {Ta, Tal, Tb, Tbl} = 4'b0000;
  endtask

  task automatic test_left_hold();
    go_s0();
    step();                       // S1
    step();                       // S2
    total++;
    if (La !== LFT) begin
      bad++;
      $display("FAIL left_reach: La=%b expected %b", La, LFT);
    end
    Tal = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (La !== LFT || Lb !== RED) begin
        bad++;
        $display("FAIL left_hold[%0d]: La=%b Lb=%b expected La=%b Lb=%b", i, La, Lb, LFT, RED);
      end
    end
    Tal = 1'b0;
    step();
    total++;
    if (La !== YEL || Lb !== RED) begin
      bad++;
      $display("FAIL left_release: La=%b Lb=%b expected La=%b Lb=%b", La, Lb, YEL, RED);
    end
    step();
    total++;
    if (La !== RED || Lb !== GRN) begin
      bad++;
      $display("FAIL left_to_b: La=%b Lb=%b expected La=%b Lb=%b", La, Lb, RED, GRN);
    end
  endtask

  task automatic test_b_side();
    go_s0();
    Tb = 1'b1;
    for (int i = 0; i < 4; i++) step();   // S1, S2, S3, S4
    for (int i = 0; i < 3; i++) begin
      total++;
      if (La !== RED || Lb !== GRN) begin
        bad++;
        $display("FAIL b_green_hold[%0d]: La=%b Lb=%b expected La=%b Lb=%b", i, La, Lb, RED, GRN);
      end
      if (i < 2) step();
    end
    Tb = 1'b0;
    step();
    total++;
    if (La !== RED || Lb !== YEL) begin
      bad++;
      $display("FAIL b_yellow: La=%b Lb=%b expected La=%b Lb=%b", La, Lb, RED, YEL);
    end
    Tbl = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (La !== RED || Lb !== LFT) begin
        bad++;
        $display("FAIL b_left_hold[%0d]: La=%b Lb=%b expected La=%b Lb=%b", i, La, Lb, RED, LFT);
      end
    end
    Tbl = 1'b0;
    step();
    total++;
    if (La !== RED || Lb !== YEL) begin
      bad++;
      $display("FAIL b_left_release: La=%b Lb=%b expected La=%b Lb=%b", La, Lb, RED, YEL);
    end
    step();
    total++;
    if (La !== GRN || Lb !== RED) begin
      bad++;
      $display("FAIL b_wrap: La=%b Lb=%b expected La=%b Lb=%b", La, Lb, GRN, RED);
    end
  endtask

  task automatic test_reset_mid();
    go_s0();
    for (int i = 0; i < 5; i++) step();   // S1..S5
    total++;
    if (La !== RED || Lb !== YEL) begin
      bad++;
      $display("FAIL mid_reach_s5: La=%b Lb=%b expected La=%b Lb=%b", La, Lb, RED, YEL);
    end
    reset_n = 1'b0;
    #2;
    total++;
    if (La !== RED || Lb !== YEL) begin
      bad++;
      $display("FAIL mid_no_async: La=%b Lb=%b expected La=%b Lb=%b", La, Lb, RED, YEL);
    end
    step();
    total++;
    if (La !== GRN || Lb !== RED) begin
      bad++;
      $display("FAIL mid_reset: La=%b Lb=%b expected La=%b Lb=%b", La, Lb, GRN, RED);
    end
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    {Ta, Tal, Tb, Tbl} = 4'b0000;
    #1;
    test_reset();
    test_hold();
    test_full_cycle();
    test_ignore_other_sensors();
    test_left_hold();
    test_b_side();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
